game_display_sequencer: RTL and testbench
=========================================

// Module: game_display_sequencer
// PURPOSE
//  Owns the 16x16 LED matrix. Scans rows at a fixed dwell and, per row, chooses the
//  column-pixel source: blank, playfield, or game-over overlay. Runs the game-phase FSM
//  IDLE -> PLAY -> FLASH -> OVER, sequenced by start/hit and frame ticks. Freezes game
//  logic outside PLAY.
// PARAMETERS
//  ROWS          16    matrix rows scanned; row_addr width = $clog2(ROWS)
//  COLS          16    pixels per row
//  ROW_DWELL     1024  clocks per row (>=2)
//  FLASH_FRAMES  8     frames spent in FLASH before OVER (>=1)
//  BLINK_FRAMES  2     frames per blink half-period in FLASH (>=1)
// PORTS
//  clk          in   1        clock
//  reset        in   1        reset, synchronous, active-high
//  start        in   1        level/pulse; begin or restart game
//  hit          in   1        frog collision from playfield logic
//  play_pixels  in   COLS     playfield row data for row_addr (comb. from row_addr)
//  over_pixels  in   COLS     game-over overlay row data for row_addr (comb.)
//  row_addr     out  log2R    row being fetched (registered)
//  row_sel      out  ROWS     one-hot row drive, aligned with col_pixels
//  col_pixels   out  COLS     column drive for row selected by row_sel
//  frame_tick   out  1        1-cycle pulse at end of each full scan
//  phase        out  2        00 IDLE, 01 PLAY, 10 FLASH, 11 OVER
//  freeze       out  1        1 = game logic must hold state
// BEHAVIOUR
//  Reset: row_addr=0, dwell_cnt=0, row_sel=0, col_pixels=0, frame_tick=0, phase=IDLE,
//   freeze=1, frame/blink counters=0, blink_on=1. Reset mid-scan aborts immediately.
//  Scan: dwell_cnt counts 0..ROW_DWELL-1; on ROW_DWELL-1 it wraps to 0 and row_addr
//   increments, wrapping ROWS-1 -> 0. frame_tick=1 for exactly the cycle following
//   row_addr=ROWS-1 & dwell_cnt=ROW_DWELL-1 (registered).
//  Datapath latency 1 clk: row_sel <= onehot(row_addr), col_pixels <= src(row_addr).
//   Anti-ghost blank: when dwell_cnt==0 the registered col_pixels is 0 (row_sel still set).
//  Source select (decided by phase current in the sampling cycle):
//   IDLE: 0 | PLAY: play_pixels | FLASH: blink_on ? play_pixels : 0 | OVER: over_pixels.
//  FSM (evaluated every clk, phase registered):
//   IDLE : start -> PLAY.
//   PLAY : hit -> FLASH (hit has priority over start in same cycle); clears flash_cnt,
//          blink_cnt, sets blink_on=1.
//   FLASH: on each frame_tick flash_cnt++, blink_cnt++; blink_cnt reaching BLINK_FRAMES
//          toggles blink_on and clears blink_cnt; flash_cnt reaching FLASH_FRAMES -> OVER.
//          start and hit ignored.
//   OVER : sticky; hit ignored; start -> PLAY (restart, scan not restarted).
//  freeze = 0 only in PLAY (combinational from phase). hit outside PLAY has no effect.
//  Phase changes take effect on pixels at the next sampled row cycle; no scan realign.
//  Counter widths sized from parameters; no overflow possible in any state.
// TESTING  (ROW_DWELL=4, ROWS=16 -> 64 clk/frame, FLASH_FRAMES=4, BLINK_FRAMES=1)
//  Reset 3 clk, release -> phase=00, freeze=1, col_pixels=0, row_sel walks 0x0001,
//   0x0002.. every 4 clk; frame_tick pulses every 64 clk.
//  start=1 1 clk, play_pixels=16'hA5A5 -> phase=01, freeze=0; col_pixels=A5A5 on dwell
//   cycles 1..3 of each row, 0 on dwell cycle 0.
//  hit and start same cycle in PLAY -> phase=10; rows alternate A5A5 / 0 per frame;
//   exactly 4 frame_ticks later phase=11.
//  OVER, over_pixels=16'hF997, hit pulses -> stays 11, col_pixels=F997; start -> 01.
//  hit in IDLE -> phase stays 00; reset asserted mid-FLASH -> next clk all outputs at
//   reset values, row_addr=0.
//  Wrap: row_addr 15 -> 0 with single frame_tick; row_sel 0x8000 -> 0x0001 one clk later.

Source files
------------

// File: rtl/game_display_sequencer.sv
// -----------------------------------------------------------------------------
// game_display_sequencer
//
// Drives a ROWS x COLS LED matrix and sequences the game phases.
//
// The scan walks row_addr through every row, holding each row for ROW_DWELL
// clocks. One clock after a row is fetched, that row's one-hot select appears
// on row_sel and its column data appears on col_pixels. The data comes from one
// of three sources, chosen by the current phase:
//   IDLE  -> blank
//   PLAY  -> playfield
//   FLASH -> playfield, blinking at BLINK_FRAMES frames per half-period
//   OVER  -> game-over overlay
// The first clock of every row is forced blank so the previous row's data
// never shows under the new row select (ghosting).
//
// The phase FSM steps IDLE -> PLAY -> FLASH -> OVER. It is driven by start and
// hit and is timed by frame ticks. Game logic is frozen in every phase except
// PLAY.
//
// Ports
//   clk          in   1        clock
//   reset        in   1        synchronous, active-high reset
//   start        in   1        begin the game (from IDLE) or restart it (from OVER)
//   hit          in   1        frog collision reported by the playfield logic
//   play_pixels  in   COLS     playfield row data for row_addr (combinational)
//   over_pixels  in   COLS     game-over overlay row data for row_addr (comb.)
//   row_addr     out  log2(R)  row currently being fetched (registered)
//   row_sel      out  ROWS     one-hot row drive, aligned with col_pixels
//   col_pixels   out  COLS     column drive for the row selected by row_sel
//   frame_tick   out  1        one-cycle pulse after the last clock of a scan
//   phase        out  2        00 IDLE, 01 PLAY, 10 FLASH, 11 OVER
//   freeze       out  1        1 = game logic must hold its state
// -----------------------------------------------------------------------------
module game_display_sequencer #(
    parameter int ROWS         = 16,    // rows scanned (>=2)
    parameter int COLS         = 16,    // pixels per row
    parameter int ROW_DWELL    = 1024,  // clocks per row (>=2)
    parameter int FLASH_FRAMES = 8,     // frames spent in FLASH before OVER (>=1)
    parameter int BLINK_FRAMES = 2      // frames per blink half-period (>=1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    hit,
    input  logic [COLS-1:0]         play_pixels,
    input  logic [COLS-1:0]         over_pixels,
    output logic [$clog2(ROWS)-1:0] row_addr,
    output logic [ROWS-1:0]         row_sel,
    output logic [COLS-1:0]         col_pixels,
    output logic                    frame_tick,
    output logic [1:0]              phase,
    output logic                    freeze
);

    // -------------------------------------------------------------------------
    // Widths and terminal counts
    // -------------------------------------------------------------------------
    localparam int ROW_W   = $clog2(ROWS);
    localparam int DWELL_W = $clog2(ROW_DWELL);
    // flash_cnt reaches FLASH_FRAMES on the way into OVER, so it needs room
    // for that value. blink_cnt is cleared when it reaches its terminal count
    // and never holds BLINK_FRAMES.
    localparam int FLASH_W = $clog2(FLASH_FRAMES + 1);
    localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

    localparam logic [ROW_W-1:0]   LAST_ROW    = ROW_W'(ROWS - 1);
    localparam logic [DWELL_W-1:0] LAST_DWELL  = DWELL_W'(ROW_DWELL - 1);
    localparam logic [FLASH_W-1:0] FLASH_FINAL = FLASH_W'(FLASH_FRAMES - 1);
    localparam logic [BLINK_W-1:0] BLINK_FINAL = BLINK_W'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PLAY  = 2'b01,
        FLASH = 2'b10,
        OVER  = 2'b11
    } phase_t;

    // -------------------------------------------------------------------------
    // Row scan
    // -------------------------------------------------------------------------
    logic [DWELL_W-1:0] dwell_cnt;
    logic               row_end;
    logic               frame_end;

    assign row_end   = (dwell_cnt == LAST_DWELL);
    assign frame_end = row_end && (row_addr == LAST_ROW);

    // NOTE: state registers use non-blocking assignments. Every flop then
    // samples the values from before the clock edge, whatever order the
    // blocks are evaluated in.
    always_ff @(posedge clk) begin
        if (reset) begin
            dwell_cnt  <= '0;
            row_addr   <= '0;
            frame_tick <= 1'b0;
        end else begin
            if (row_end) begin
                dwell_cnt <= '0;
                // Wrap explicitly so that a ROWS value that is not a power of
                // two still scans correctly.
                row_addr  <= (row_addr == LAST_ROW) ? '0 : row_addr + 1'b1;
            end else begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end
            frame_tick <= frame_end;
        end
    end

    // -------------------------------------------------------------------------
    // Phase FSM: state register
    // -------------------------------------------------------------------------
    phase_t             phase_q,     phase_d;
    logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q,  blink_on_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q     <= IDLE;
            flash_cnt_q <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            phase_q     <= phase_d;
            flash_cnt_q <= flash_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    // -------------------------------------------------------------------------
    // Phase FSM: next state
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here first gets a hold value. Without that, a
    // path through the case that leaves a signal unassigned would infer a
    // latch.
    always_comb begin
        phase_d     = phase_q;
        flash_cnt_d = flash_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;

        case (phase_q)
            IDLE: begin
                if (start) phase_d = PLAY;
            end

            PLAY: begin
                // hit wins over start; a start in PLAY does nothing anyway.
                if (hit) begin
                    phase_d     = FLASH;
                    flash_cnt_d = '0;
                    blink_cnt_d = '0;
                    blink_on_d  = 1'b1;
                end
            end

            FLASH: begin
                // start and hit are ignored; only frame ticks move FLASH on.
                if (frame_tick) begin
                    flash_cnt_d = flash_cnt_q + 1'b1;
                    if (flash_cnt_q == FLASH_FINAL) phase_d = OVER;

                    if (blink_cnt_q == BLINK_FINAL) begin
                        blink_cnt_d = '0;
                        blink_on_d  = ~blink_on_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end
            end

            OVER: begin
                // Sticky until restart. The scan keeps running and is not
                // realigned on restart.
                if (start) phase_d = PLAY;
            end

            default: phase_d = IDLE;
        endcase
    end

    assign phase  = phase_q;
    assign freeze = (phase_q != PLAY);

    // -------------------------------------------------------------------------
    // Pixel datapath (one clock of latency from row_addr)
    // -------------------------------------------------------------------------
    logic [COLS-1:0] src_pixels;
    logic [ROWS-1:0] row_onehot;

    always_comb begin
        src_pixels = '0;
        case (phase_q)
            PLAY:    src_pixels = play_pixels;
            FLASH:   src_pixels = blink_on_q ? play_pixels : '0;
            OVER:    src_pixels = over_pixels;
            default: src_pixels = '0;
        endcase
    end

    always_comb begin
        row_onehot           = '0;
        row_onehot[row_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_sel    <= '0;
            col_pixels <= '0;
        end else begin
            row_sel    <= row_onehot;
            // Blank the first clock of each row. Without it, the previous
            // row's data would show while the row drivers switch over.
            col_pixels <= (dwell_cnt == '0) ? '0 : src_pixels;
        end
    end

endmodule

// File: tb/tb_game_display_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_display_sequencer
//
// Scoreboard bench. Each stimulus step pushes the outputs it expects, tagged
// with the clock cycle at which they must appear. A separate monitor samples
// the DUT on the falling edge, pops every entry due in that cycle and compares
// it with the DUT outputs.
//
// Timeline: reset is held for 3 rising edges. Scan step m counts the
// non-reset rising edges after release, so absolute cycle = 3 + m.
// With ROW_DWELL=4 and ROWS=16, one frame lasts 64 clocks.
// -----------------------------------------------------------------------------
module tb_game_display_sequencer;

    localparam int BASE = 3;

    typedef enum int {
        S_PHASE, S_FREEZE, S_ROWSEL, S_COLS, S_TICK, S_ROWADDR
    } sig_e;

    typedef struct {
        int          cyc;
        sig_e        sig;
        logic [15:0] val;
        string       name;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        hit;
    logic [15:0] play_pixels;
    logic [15:0] over_pixels;
    logic [3:0]  row_addr;
    logic [15:0] row_sel;
    logic [15:0] col_pixels;
    logic        frame_tick;
    logic [1:0]  phase;
    logic        freeze;

    exp_t q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    game_display_sequencer #(
        .ROWS         (16),
        .COLS         (16),
        .ROW_DWELL    (4),
        .FLASH_FRAMES (4),
        .BLINK_FRAMES (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .hit         (hit),
        .play_pixels (play_pixels),
        .over_pixels (over_pixels),
        .row_addr    (row_addr),
        .row_sel     (row_sel),
        .col_pixels  (col_pixels),
        .frame_tick  (frame_tick),
        .phase       (phase),
        .freeze      (freeze)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Queue an expected output value for scan step m.
    task automatic exp_at(input int m, input sig_e s, input logic [15:0] v,
                          input string name);
        exp_t e;
        e.cyc  = BASE + m;
        e.sig  = s;
        e.val  = v;
        e.name = name;
        q.push_back(e);
    endtask

    // Return 1 ns after the rising edge of scan step m. Inputs set there are
    // sampled on edge m+1.
    task automatic run_to(input int m);
        while (cyc < BASE + m) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares every expectation that is due in this cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] act;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            case (e.sig)
                S_PHASE:   act = {14'b0, phase};
                S_FREEZE:  act = {15'b0, freeze};
                S_ROWSEL:  act = row_sel;
                S_COLS:    act = col_pixels;
                S_TICK:    act = {15'b0, frame_tick};
                default:   act = {12'b0, row_addr};
            endcase
            total = total + 1;
            if (e.cyc != cyc) begin
                bad = bad + 1;
                $display("FAIL %s: expectation for cycle %0d missed (now cycle %0d)",
                         e.name, e.cyc, cyc);
            end else if (act !== e.val) begin
                bad = bad + 1;
                $display("FAIL %s @cycle %0d: got %h, expected %h",
                         e.name, cyc, act, e.val);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        hit         = 1'b0;
        play_pixels = 16'hA5A5;
        over_pixels = 16'hF997;

        // ---- Reset values, idle scan, frame wrap, hit ignored in IDLE ----
        exp_at(0,  S_PHASE,   16'h0000, "rst_phase");
        exp_at(0,  S_FREEZE,  16'h0001, "rst_freeze");
        exp_at(0,  S_ROWSEL,  16'h0000, "rst_row_sel");
        exp_at(0,  S_COLS,    16'h0000, "rst_cols");
        exp_at(0,  S_TICK,    16'h0000, "rst_tick");
        exp_at(0,  S_ROWADDR, 16'h0000, "rst_row_addr");
        exp_at(1,  S_ROWSEL,  16'h0001, "idle_row0_sel");
        exp_at(1,  S_COLS,    16'h0000, "idle_row0_blank");
        exp_at(2,  S_COLS,    16'h0000, "idle_cols_zero");
        exp_at(5,  S_ROWSEL,  16'h0002, "idle_row1_sel");
        exp_at(10, S_PHASE,   16'h0000, "idle_hit_phase_a");
        exp_at(11, S_PHASE,   16'h0000, "idle_hit_phase_b");
        exp_at(11, S_FREEZE,  16'h0001, "idle_hit_freeze");
        exp_at(61, S_ROWSEL,  16'h8000, "row15_sel");
        exp_at(63, S_ROWADDR, 16'h000F, "row_addr_15");
        exp_at(63, S_TICK,    16'h0000, "no_tick_early");
        exp_at(64, S_TICK,    16'h0001, "tick_frame1");
        exp_at(64, S_ROWADDR, 16'h0000, "row_addr_wrap");
        exp_at(64, S_ROWSEL,  16'h8000, "row15_sel_held");
        exp_at(65, S_TICK,    16'h0000, "tick_single");
        exp_at(65, S_ROWSEL,  16'h0001, "row_sel_wrap");
        exp_at(128, S_TICK,   16'h0001, "tick_frame2");
        run_to(0);
        reset = 1'b0;
        run_to(9);
        hit = 1'b1;
        run_to(10);
        hit = 1'b0;

        // ---- start -> PLAY ----
        run_to(128);
        exp_at(131, S_PHASE,  16'h0001, "play_phase");
        exp_at(131, S_FREEZE, 16'h0000, "play_freeze");
        exp_at(131, S_COLS,   16'h0000, "play_prev_idle_src");
        exp_at(132, S_COLS,   16'hA5A5, "play_dwell3");
        exp_at(133, S_COLS,   16'h0000, "play_dwell0_blank");
        exp_at(133, S_ROWSEL, 16'h0002, "play_row1_sel");
        exp_at(134, S_COLS,   16'hA5A5, "play_dwell1");
        run_to(130);
        start = 1'b1;
        run_to(131);
        start = 1'b0;

        // ---- hit+start together in PLAY -> FLASH, blink, 4 frames -> OVER ----
        exp_at(142, S_PHASE,  16'h0002, "flash_phase");
        exp_at(142, S_FREEZE, 16'h0001, "flash_freeze");
        exp_at(142, S_COLS,   16'hA5A5, "flash_blink_on");
        exp_at(152, S_PHASE,  16'h0002, "flash_hit_ignored");
        exp_at(162, S_PHASE,  16'h0002, "flash_start_ignored");
        exp_at(190, S_COLS,   16'hA5A5, "flash_frame_a_on");
        exp_at(192, S_TICK,   16'h0001, "flash_tick1");
        exp_at(200, S_COLS,   16'h0000, "flash_frame_b_off");
        exp_at(262, S_COLS,   16'hA5A5, "flash_frame_c_on");
        exp_at(330, S_COLS,   16'h0000, "flash_frame_d_off");
        exp_at(384, S_PHASE,  16'h0002, "flash_before_4th");
        exp_at(384, S_TICK,   16'h0001, "flash_tick4");
        exp_at(385, S_PHASE,  16'h0003, "over_phase");
        run_to(140);
        start = 1'b1;
        hit   = 1'b1;
        run_to(141);
        start = 1'b0;
        hit   = 1'b0;
        run_to(150);
        hit = 1'b1;
        run_to(151);
        hit = 1'b0;
        run_to(160);
        start = 1'b1;
        run_to(161);
        start = 1'b0;

        // ---- OVER: overlay shown, hit ignored, start restarts ----
        run_to(380);
        exp_at(386, S_COLS,   16'hF997, "over_pixels_a");
        exp_at(386, S_FREEZE, 16'h0001, "over_freeze");
        exp_at(388, S_COLS,   16'hF997, "over_pixels_b");
        exp_at(389, S_COLS,   16'h0000, "over_dwell0_blank");
        exp_at(392, S_PHASE,  16'h0003, "over_hit1_ignored");
        exp_at(397, S_PHASE,  16'h0003, "over_hit2_ignored");
        exp_at(400, S_PHASE,  16'h0003, "over_sticky");
        exp_at(401, S_PHASE,  16'h0001, "restart_phase");
        exp_at(401, S_FREEZE, 16'h0000, "restart_freeze");
        exp_at(403, S_COLS,   16'hA5A5, "restart_pixels");
        run_to(390);
        hit = 1'b1;
        run_to(391);
        hit = 1'b0;
        run_to(395);
        hit = 1'b1;
        run_to(396);
        hit = 1'b0;
        run_to(400);
        start = 1'b1;
        run_to(401);
        start = 1'b0;

        // ---- reset asserted mid-FLASH ----
        exp_at(412, S_PHASE,   16'h0002, "flash2_phase");
        exp_at(420, S_PHASE,   16'h0002, "pre_reset_phase");
        exp_at(420, S_ROWADDR, 16'h0009, "pre_reset_row_addr");
        exp_at(421, S_PHASE,   16'h0000, "mid_rst_phase");
        exp_at(421, S_FREEZE,  16'h0001, "mid_rst_freeze");
        exp_at(421, S_ROWADDR, 16'h0000, "mid_rst_row_addr");
        exp_at(421, S_ROWSEL,  16'h0000, "mid_rst_row_sel");
        exp_at(421, S_COLS,    16'h0000, "mid_rst_cols");
        exp_at(421, S_TICK,    16'h0000, "mid_rst_tick");
        exp_at(422, S_ROWSEL,  16'h0001, "post_rst_row0");
        exp_at(422, S_PHASE,   16'h0000, "post_rst_phase");
        run_to(410);
        hit = 1'b1;
        run_to(411);
        hit = 1'b0;
        run_to(420);
        reset = 1'b1;
        run_to(421);
        reset = 1'b0;

        run_to(430);
        @(negedge clk);
        #1;
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL %s: expectation for cycle %0d never compared",
                     e.name, e.cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
